// File: rtl/spectrum_bands.sv
// spectrum_bands: sums the lower half-spectrum of each FFT frame into NBANDS
// equal-width bands (double-buffered) and streams one log-compressed level
// per band over a valid/ready interface when the frame ends.
// Optional build macro PEAK_HOLD_EN: per-band peak hold with decay of 1 per frame.
// Assumes NBANDS >= 2, ACC_W <= 63.
module spectrum_bands #(
   parameter int unsigned MAG_W     = 32,
   parameter int unsigned IDX_W     = 10,
   parameter int unsigned BIN_SHIFT = 5,
   parameter int unsigned NBANDS    = 16,
   parameter int unsigned ACC_W     = 40
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      mag_valid,
   input  logic [MAG_W-1:0]          mag,
   input  logic [IDX_W-1:0]          mag_index,
   output logic                      band_valid,
   input  logic                      band_ready,
   output logic [$clog2(NBANDS)-1:0] band_id,
   output logic [7:0]                band_level,
   output logic                      band_last,
   output logic                      overrun
);

   localparam int unsigned BID_W = $clog2(NBANDS);
   localparam int unsigned SPAN  = NBANDS << BIN_SHIFT;
   localparam int unsigned SUM_W = ((MAG_W > ACC_W) ? MAG_W : ACC_W) + 1;

   typedef enum logic {IDLE, DRAIN} state_t;
   state_t state;

   logic [ACC_W-1:0] acc    [NBANDS];
   logic [ACC_W-1:0] acc_nx [NBANDS];
   logic [ACC_W-1:0] obuf   [NBANDS];

   logic             in_range;
   logic             frame_end;
   logic             transfer;
   logic             accept;
   logic [BID_W-1:0] sel;
   logic [SUM_W-1:0] sum;

   assign in_range  = mag_valid && ({1'b0, mag_index} < (IDX_W+1)'(SPAN));
   assign frame_end = mag_valid && (mag_index == '1);
   assign sel       = BID_W'(mag_index >> BIN_SHIFT);
   assign transfer  = band_valid && band_ready;
   // A frame end is taken when idle, or when the final band leaves in the same cycle.
   assign accept    = (state == IDLE) || (transfer && band_last);

   // Accumulator next-state: saturating add of the current beat into its band.
   always_comb begin
      acc_nx = acc;
      sum    = SUM_W'(acc[sel]) + SUM_W'(mag);
      if (in_range)
         acc_nx[sel] = (sum > SUM_W'({ACC_W{1'b1}})) ? '1 : ACC_W'(sum);
   end

   // Band accumulators and output buffer; frame end hands acc (with this beat) to obuf.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned b = 0; b < NBANDS; b++) begin
            acc[b]  <= '0;
            obuf[b] <= '0;
         end
      end else begin
         for (int unsigned b = 0; b < NBANDS; b++) begin
            acc[b] <= frame_end ? '0 : acc_nx[b];
            if (frame_end && accept)
               obuf[b] <= acc_nx[b];
         end
      end
   end

   // Drain FSM: registered valid/id/last, sticky overrun on dropped frames.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         band_valid <= 1'b0;
         band_id    <= '0;
         band_last  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (frame_end && !accept)
            overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (frame_end) begin
                  state      <= DRAIN;
                  band_valid <= 1'b1;
                  band_id    <= '0;
                  band_last  <= 1'b0;
               end
            end
            DRAIN: begin
               if (transfer) begin
                  if (band_last) begin
                     band_id   <= '0;
                     band_last <= 1'b0;
                     // Back-to-back frame: restart the drain instead of going idle.
                     if (!frame_end) begin
                        state      <= IDLE;
                        band_valid <= 1'b0;
                     end
                  end else begin
                     band_id   <= band_id + 1'b1;
                     band_last <= (band_id == BID_W'(NBANDS - 2));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [ACC_W-1:0] lv_v;
   logic [ACC_W-1:0] lv_sh;
   logic [5:0]       lv_p;
   logic [7:0]       lvl;

   // Log compression: {msb position + 1, next two bits below the msb}.
   always_comb begin
      lv_v = obuf[band_id];
      lv_p = '0;
      for (int unsigned i = 0; i < ACC_W; i++)
         if (lv_v[i]) lv_p = 6'(i);
      // Left-justify the msb so the two following bits (zero below bit 0) sit at the top.
      lv_sh = lv_v << (6'(ACC_W - 1) - lv_p);
      lvl   = (lv_v == '0) ? 8'd0 : {lv_p + 6'd1, lv_sh[ACC_W-2], lv_sh[ACC_W-3]};
   end

`ifdef PEAK_HOLD_EN
   logic [7:0] held [NBANDS];
   logic [7:0] decay;
   logic [7:0] hold_lvl;

   // Peak hold: emit the larger of the new level and the decayed held level.
   always_comb begin
      decay    = (held[band_id] == 8'd0) ? 8'd0 : held[band_id] - 8'd1;
      hold_lvl = (lvl > decay) ? lvl : decay;
   end

   assign band_level = hold_lvl;

   // Held level is updated only when the band is actually transferred.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned b = 0; b < NBANDS; b++)
            held[b] <= '0;
      end else if (transfer) begin
         held[band_id] <= hold_lvl;
      end
   end
`else
   assign band_level = lvl;
`endif

endmodule
